// File: rtl/stream_sum_engine.sv
// -----------------------------------------------------------------------------
// stream_sum_engine
// Accumulates a stream of unsigned beats into a 24-bit sum and counts the
// clock cycles spent accumulating. A run begins with a one-cycle start pulse
// and ends when a valid beat carrying in_last is accepted; done then stays
// high, with sum and cycle frozen, until the next start or reset.
//
// Ports:
//   clk       - clock; all state changes on its rising edge
//   reset     - asynchronous active-high reset
//   start     - one-cycle request to begin a new run (ignored while accumulating)
//   in_valid  - in_data / in_last are valid this cycle
//   in_ready  - the block accepts a beat this cycle (high only while accumulating)
//   in_data   - unsigned operand, DATA_W bits (1..24)
//   in_last   - marks the final beat of a run
//   sum       - running / final 24-bit sum
//   cycle     - clock cycles spent accumulating, saturating at 1023
//   done      - run complete; sum and cycle are final
//
// Configuration:
//   STREAM_SUM_SATURATE_EN - when defined, sum clamps at 24'hFFFFFF on
//                            overflow; otherwise it wraps modulo 2^24.
// -----------------------------------------------------------------------------
module stream_sum_engine #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic [23:0]       sum,
    output logic [9:0]        cycle,
    output logic              done
);

    localparam int unsigned SUM_W = 24;
    localparam int unsigned CYC_W = 10;
    localparam logic [CYC_W-1:0] CYC_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [SUM_W-1:0] data_ext;
    logic [SUM_W-1:0] sum_next;
    logic             beat_accept;

    // Operand zero-extended to the accumulator width.
    assign data_ext = SUM_W'(in_data);

`ifdef STREAM_SUM_SATURATE_EN
    // One extra bit catches the carry out; any carry clamps to all ones.
    logic [SUM_W:0] sum_wide;
    assign sum_wide = {1'b0, sum} + {1'b0, data_ext};
    assign sum_next = sum_wide[SUM_W] ? {SUM_W{1'b1}} : sum_wide[SUM_W-1:0];
`else
    // Plain modulo-2^24 accumulation.
    assign sum_next = sum + data_ext;
`endif

    // Ready depends only on the registered state, never on in_valid.
    assign in_ready    = (state == ACCUM);
    assign beat_accept = in_ready && in_valid;

    // Run control, accumulator and cycle counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sum   <= '0;
            cycle <= '0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sum   <= '0;
                        cycle <= '0;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    // Every accumulating edge counts, including the last-beat edge.
                    if (cycle != CYC_MAX) begin
                        cycle <= cycle + CYC_W'(1);
                    end
                    if (beat_accept) begin
                        sum <= sum_next;
                        if (in_last) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        sum   <= '0;
                        cycle <= '0;
                        done  <= 1'b0;
                        state <= ACCUM;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/stream_sum_engine.md
STREAM_SUM_ENGINE -- requirements
Module: stream_sum_engine

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the input data width (legal 1..24).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: single-cycle request to begin a new summation.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_data/in_last valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-007 The block SHALL have port in_data, input, DATA_W bits: unsigned operand.
REQ-008 The block SHALL have port in_last, input, 1 bit: marks the final beat of a run.
REQ-009 The block SHALL have port sum, output, 24 bits: running/final sum, fed to the hex display path.
REQ-010 The block SHALL have port cycle, output, 10 bits: clock cycles spent in ACCUM.
REQ-011 The block SHALL have port done, output, 1 bit: the run is complete and sum/cycle are final.

Function
REQ-012 The FSM SHALL have states IDLE, ACCUM and DONE, all registered.
REQ-013 IDLE + start SHALL clear sum and cycle and enter ACCUM on the next edge; start SHALL be ignored while in ACCUM.
REQ-014 DONE + start SHALL clear sum and cycle, deassert done, and enter ACCUM on the next edge.
REQ-015 in_ready SHALL be 1 exactly when the state is ACCUM (combinational from state only, never from in_valid).
REQ-016 A beat is accepted when in_valid and in_ready are both 1: sum <= sum + zero-extended in_data on that edge (one-cycle latency to the sum output).
REQ-017 cycle SHALL increment by 1 on every edge spent in ACCUM, including the edge accepting the last beat, with or without a valid beat, saturating at 1023.
REQ-018 An accepted beat with in_last=1 SHALL move the FSM to DONE; done SHALL assert on that same edge and stay high until the next start or reset.
REQ-019 in_last without in_valid SHALL have no effect.
REQ-020 In IDLE and DONE, sum and cycle SHALL hold their values, and in_data/in_valid SHALL be ignored.
REQ-021 Arithmetic overflow beyond 24 bits SHALL follow REQ-025.

Reset
REQ-022 Asserting reset SHALL immediately force state=IDLE, sum=0, cycle=0, done=0, in_ready=0, regardless of clk.
REQ-023 Reset during ACCUM SHALL abort the run; no partial result persists, and a fresh start is needed.
REQ-024 After reset deasserts, the first edge SHALL be able to accept start.

Configuration
REQ-025 With macro STREAM_SUM_SATURATE_EN defined, sum SHALL clamp at 24'hFFFFFF on overflow; without it, sum SHALL wrap modulo 2^24.

Verification
REQ-026 After reset, start, then 4 back-to-back beats 1,2,3,4 (last on 4) -> sum=10, cycle=4, done=1, in_ready=0.
REQ-027 start, then beats 5 and 7 (last) with 3 idle in_valid=0 cycles between them -> sum=12, cycle=5, done=1.
REQ-028 DATA_W=24, start, beats 24'hFFFFF0 and 24'h20 (last) -> sum=24'h000010 without the macro; sum=24'hFFFFFF with STREAM_SUM_SATURATE_EN.
REQ-029 start, then in_valid=0 for 1100 cycles, then beat 1 with last -> cycle=1023 (saturated), sum=1.
REQ-030 Reset pulse mid-run after 2 beats, then start and beat 9 (last) -> sum=9, cycle=1; start pulses during ACCUM have no effect.
REQ-031 From DONE with sum=10, pulse start -> next cycle done=0, sum=0, cycle=0, in_ready=1.
